// File: rtl/mem_stage_if.sv
// mem_stage_if: ready-handshaked word data-memory bus between the MEM stage and data memory.
interface mem_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  modport master(output req, we, addr, wdata, input ready, rdata);
  modport slave(input req, we, addr, wdata, output ready, rdata);
endinterface

// File: rtl/mem_stage.sv
// mem_stage: RV32 MEM stage - branch resolve, word load/store with wait-state freeze, MEM/WB register.
// Optional MEM_TIMEOUT_EN aborts an access stalled TIMEOUT_CYC cycles and sets sticky mem_err.
module mem_stage #(
  parameter int TIMEOUT_CYC = 16,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   exm_valid,
  input  logic [5:0]             exm_ctrl,
  input  logic [100:0]           exm_data,
  mem_stage_if.master            dmem,
  output logic                   mem_stall,
  output logic                   pc_src,
  output logic [31:0]            branch_target,
  output logic                   wb_valid,
  output logic                   wb_reg_write,
  output logic                   wb_mem_to_reg,
  output logic [31:0]            wb_rdata,
  output logic [31:0]            wb_alu_result,
  output logic [4:0]             wb_rd,
  output logic [STALL_CNT_W-1:0] stall_cycles,
  output logic                   mem_err
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t      state;
  logic        reg_write, mem_to_reg, branch, mem_read, mem_write, alu_zero;
  logic [31:0] alu_result;
  logic [4:0]  rd;
  logic        mem_op, abort, load_done;
  assign {reg_write, mem_to_reg, branch, mem_read, mem_write, alu_zero} = exm_ctrl;
  assign branch_target = exm_data[100:69];
  assign alu_result    = exm_data[68:37];
  assign rd            = exm_data[4:0];
  assign mem_op    = exm_valid & (mem_read | mem_write);
  assign dmem.req   = rst_n & mem_op & ~abort;
  assign dmem.we    = mem_write;
  assign dmem.addr  = alu_result;
  assign dmem.wdata = exm_data[36:5];
  assign mem_stall = dmem.req & ~dmem.ready;
  assign load_done = dmem.req & dmem.ready & ~mem_write;
  assign pc_src    = exm_valid & branch & alu_zero;
`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TO = 8'(TIMEOUT_CYC);
  logic [7:0] wait_cnt;
  assign abort = (state == WAIT) && (wait_cnt == TO);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      wait_cnt <= mem_stall ? wait_cnt + 8'd1 : 8'd0;
      mem_err  <= mem_err | abort;
    end
`else
  assign abort   = 1'b0;
  assign mem_err = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= (state == IDLE) ? ((mem_op & ~dmem.ready) ? WAIT : IDLE)
                                  : ((dmem.ready | abort) ? IDLE : WAIT);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stall_cycles <= '0;
    else if (mem_stall && !(&stall_cycles)) stall_cycles <= stall_cycles + STALL_CNT_W'(1);
  // A stalled edge injects a bubble; the held instruction retires on its completing edge.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_rdata      <= '0;
      wb_alu_result <= '0;
      wb_rd         <= '0;
    end else if (mem_stall) begin
      wb_valid <= 1'b0;
    end else begin
      wb_valid      <= exm_valid;
      wb_reg_write  <= exm_valid & reg_write & ~abort;
      wb_mem_to_reg <= mem_to_reg;
      wb_rdata      <= load_done ? dmem.rdata : 32'd0;
      wb_alu_result <= alu_result;
      wb_rd         <= rd;
    end
endmodule
